accumulator_control: RTL and testbench

Multicycle control FSM for the accumulator CPU: drives every control input of the top-level datapath (PC unit, register/wires subsystem, ALU subsystem, memory subsystem) from the fetched opcode, ALU `Zero` and a memory-ready handshake. It is the control end of the datapath's control bus; the datapath only consumes these signals. Moore outputs, decoded from the current state and the latched opcode.

---
 rtl/accumulator_control.sv | 205 ++++++++++++++++++++
 tb/tb_accumulator_control.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_control.sv
// accumulator_control
// Multicycle control FSM for the accumulator CPU. It drives every control
// input of the datapath (PC unit, register/wires subsystem, ALU subsystem,
// memory subsystem) from the fetched opcode, the memory-ready handshake and
// the current state. Outputs are Moore style: decoded from the state and the
// opcode latched in DECODE. The only exception is FETCH, where IRWrite and
// PCWrite are gated by MemReady.
//
// Ports:
//   CLK       in  1  system clock, rising edge
//   reset     in  1  synchronous, active-high
//   Opcode    in  4  IR[15:12], valid from DECODE onward
//   MemReady  in  1  memory completes the access this cycle
//   PCWrite   out 1  unconditional PC load
//   Branch    out 1  conditional PC load
//   bneOrbeq  out 1  0 = BEQ (load if Zero), 1 = BNE (load if !Zero)
//   PCSrc     out 2  0 ALU result, 1 jump target, 2 aluOut register
//   IRWrite   out 1  instruction register load
//   MemRead   out 1  memory read strobe
//   MemWrite  out 1  memory write strobe
//   IorD      out 2  memory address: 0 PC, 1 ZE(imm), 2 SP
//   AccWrite  out 1  accumulator load
//   AccSrc    out 1  accumulator source: 0 ALU, 1 MDR
//   SpWrite   out 1  stack pointer load
//   SrcA      out 2  ALU A: 0 PC, 1 ACC, 2 SP
//   SrcB      out 3  ALU B: 0 const 2, 1 MDR, 2 SE, 3 ZE, 4 SL1
//   ALUOP     out 3  0 add, 1 sub, 2 and, 3 or, 5 passA
//   Halted    out 1  FSM is in HALT
module accumulator_control (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       Branch,
    output logic       bneOrbeq,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] IorD,
    output logic       AccWrite,
    output logic       AccSrc,
    output logic       SpWrite,
    output logic [1:0] SrcA,
    output logic [2:0] SrcB,
    output logic [2:0] ALUOP,
    output logic       Halted
);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_BEQ   = 4'h5;
    localparam logic [3:0] OP_BNE   = 4'h6;
    localparam logic [3:0] OP_JUMP  = 4'h7;
    localparam logic [3:0] OP_PUSH  = 4'h8;
    localparam logic [3:0] OP_POP   = 4'h9;
    localparam logic [3:0] OP_AND   = 4'hA;
    localparam logic [3:0] OP_OR    = 4'hB;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MRD, S_EXEC, S_LWB, S_ST,
        S_BR, S_JMP, S_PDEC, S_PWR, S_PRD, S_PINC, S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;

    // State and opcode registers. The opcode is captured only in DECODE so
    // that later IR changes cannot redirect an instruction in flight.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= S_RST;
            opcode_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state logic. DECODE dispatches on the live Opcode because that is
    // the cycle it gets latched; later states use the latched copy.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        unique case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                opcode_d = Opcode;
                case (Opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD: state_d = S_MRD;
                    OP_ADDI:         state_d = S_EXEC;
                    OP_STORE:        state_d = S_ST;
                    OP_BEQ, OP_BNE:  state_d = S_BR;
                    OP_JUMP:         state_d = S_JMP;
                    OP_PUSH:         state_d = S_PDEC;
                    OP_POP:          state_d = S_PRD;
                    default:         state_d = S_HALT;
                endcase
            end
            S_MRD:    if (MemReady) state_d = (opcode_q == OP_LOAD) ? S_LWB : S_EXEC;
            S_EXEC:   state_d = S_FETCH;
            S_LWB:    state_d = S_FETCH;
            S_ST:     if (MemReady) state_d = S_FETCH;
            S_BR:     state_d = S_FETCH;
            S_JMP:    state_d = S_FETCH;
            S_PDEC:   state_d = S_PWR;
            S_PWR:    if (MemReady) state_d = S_FETCH;
            S_PRD:    if (MemReady) state_d = S_PINC;
            S_PINC:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_RST;
        endcase
    end

    // Output decode. Every signal defaults to 0; each state raises only what
    // it needs.
    always_comb begin
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        bneOrbeq = 1'b0;
        PCSrc    = 2'd0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 2'd0;
        AccWrite = 1'b0;
        AccSrc   = 1'b0;
        SpWrite  = 1'b0;
        SrcA     = 2'd0;
        SrcB     = 3'd0;
        ALUOP    = 3'd0;
        Halted   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                // PC+2 is computed every cycle, but IR and PC only commit
                // once the memory actually delivers the instruction.
                MemRead = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: SrcB = 3'd4;
            S_MRD: begin
                MemRead = 1'b1;
                IorD    = 2'd1;
            end
            S_EXEC: begin
                SrcA     = 2'd1;
                SrcB     = (opcode_q == OP_ADDI) ? 3'd2 : 3'd1;
                AccWrite = 1'b1;
                case (opcode_q)
                    OP_SUB:  ALUOP = 3'd1;
                    OP_AND:  ALUOP = 3'd2;
                    OP_OR:   ALUOP = 3'd3;
                    default: ALUOP = 3'd0;
                endcase
            end
            S_LWB: begin
                AccWrite = 1'b1;
                AccSrc   = 1'b1;
            end
            S_ST: begin
                MemWrite = 1'b1;
                IorD     = 2'd1;
            end
            S_BR: begin
                SrcA     = 2'd1;
                ALUOP    = 3'd5;
                Branch   = 1'b1;
                bneOrbeq = (opcode_q == OP_BNE);
                PCSrc    = 2'd2;
            end
            S_JMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'd1;
            end
            S_PDEC: begin
                SrcA    = 2'd2;
                ALUOP   = 3'd1;
                SpWrite = 1'b1;
            end
            S_PWR: begin
                MemWrite = 1'b1;
                IorD     = 2'd2;
            end
            S_PRD: begin
                MemRead = 1'b1;
                IorD    = 2'd2;
            end
            S_PINC: begin
                AccWrite = 1'b1;
                AccSrc   = 1'b1;
                SrcA     = 2'd2;
                SpWrite  = 1'b1;
            end
            S_HALT:  Halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_accumulator_control.sv
// Testbench for accumulator_control. Each cycle's expected control word is
// pushed to a scoreboard queue when the stimulus is driven and popped and
// compared against the DUT outputs on the falling edge.
module tb_accumulator_control;

    typedef struct packed {
        logic       pcWrite;
        logic       branch;
        logic       bneOrbeq;
        logic [1:0] pcSrc;
        logic       irWrite;
        logic       memRead;
        logic       memWrite;
        logic [1:0] iorD;
        logic       accWrite;
        logic       accSrc;
        logic       spWrite;
        logic [1:0] srcA;
        logic [2:0] srcB;
        logic [2:0] aluOp;
        logic       halted;
    } ctrl_t;

    logic       CLK;
    logic       reset;
    logic [3:0] Opcode;
    logic       MemReady;
    ctrl_t      observed;

    ctrl_t expQ[$];
    int    checkCount = 0;
    int    errorCount = 0;

    accumulator_control dut (
        .CLK      (CLK),
        .reset    (reset),
        .Opcode   (Opcode),
        .MemReady (MemReady),
        .PCWrite  (observed.pcWrite),
        .Branch   (observed.branch),
        .bneOrbeq (observed.bneOrbeq),
        .PCSrc    (observed.pcSrc),
        .IRWrite  (observed.irWrite),
        .MemRead  (observed.memRead),
        .MemWrite (observed.memWrite),
        .IorD     (observed.iorD),
        .AccWrite (observed.accWrite),
        .AccSrc   (observed.accSrc),
        .SpWrite  (observed.spWrite),
        .SrcA     (observed.srcA),
        .SrcB     (observed.srcB),
        .ALUOP    (observed.aluOp),
        .Halted   (observed.halted)
    );

    // Free-running 10-unit clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected control words for each state, written directly from the
    // state descriptions; anything not mentioned stays 0.
    function automatic ctrl_t expZero();
        ctrl_t c = '0;
        return c;
    endfunction

    function automatic ctrl_t expFetch(input logic ready);
        ctrl_t c = '0;
        c.memRead = 1'b1;
        c.irWrite = ready;
        c.pcWrite = ready;
        return c;
    endfunction

    function automatic ctrl_t expDecode();
        ctrl_t c = '0;
        c.srcB = 3'd4;
        return c;
    endfunction

    function automatic ctrl_t expMrd();
        ctrl_t c = '0;
        c.memRead = 1'b1;
        c.iorD    = 2'd1;
        return c;
    endfunction

    function automatic ctrl_t expExec(input logic [3:0] op);
        ctrl_t c = '0;
        c.srcA     = 2'd1;
        c.srcB     = (op == 4'h2) ? 3'd2 : 3'd1;
        c.accWrite = 1'b1;
        c.aluOp    = (op == 4'h1) ? 3'd1 : (op == 4'hA) ? 3'd2 : (op == 4'hB) ? 3'd3 : 3'd0;
        return c;
    endfunction

    function automatic ctrl_t expLwb();
        ctrl_t c = '0;
        c.accWrite = 1'b1;
        c.accSrc   = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t expSt();
        ctrl_t c = '0;
        c.memWrite = 1'b1;
        c.iorD     = 2'd1;
        return c;
    endfunction

    function automatic ctrl_t expBr(input logic bne);
        ctrl_t c = '0;
        c.srcA     = 2'd1;
        c.aluOp    = 3'd5;
        c.branch   = 1'b1;
        c.bneOrbeq = bne;
        c.pcSrc    = 2'd2;
        return c;
    endfunction

    function automatic ctrl_t expJmp();
        ctrl_t c = '0;
        c.pcWrite = 1'b1;
        c.pcSrc   = 2'd1;
        return c;
    endfunction

    function automatic ctrl_t expPdec();
        ctrl_t c = '0;
        c.srcA    = 2'd2;
        c.aluOp   = 3'd1;
        c.spWrite = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t expPwr();
        ctrl_t c = '0;
        c.memWrite = 1'b1;
        c.iorD     = 2'd2;
        return c;
    endfunction

    function automatic ctrl_t expPrd();
        ctrl_t c = '0;
        c.memRead = 1'b1;
        c.iorD    = 2'd2;
        return c;
    endfunction

    function automatic ctrl_t expPinc();
        ctrl_t c = '0;
        c.accWrite = 1'b1;
        c.accSrc   = 1'b1;
        c.srcA     = 2'd2;
        c.spWrite  = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t expHalt();
        ctrl_t c = '0;
        c.halted = 1'b1;
        return c;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input ctrl_t obs, input ctrl_t exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%06h expected=%06h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue the expected word, compare on the
    // falling edge, then advance past the next rising edge.
    task automatic applyStimulus(input string tag, input logic [3:0] op,
                                 input logic ready, input ctrl_t exp);
        ctrl_t e;
        Opcode   = op;
        MemReady = ready;
        expQ.push_back(exp);
        @(negedge CLK);
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, observed, ~exp);
        end else begin
            e = expQ.pop_front();
            checkOutput(tag, observed, e);
        end
        @(posedge CLK);
        #1;
    endtask

    // A memory state: MemReady low for 'waits' cycles, then high once.
    // The control word must stay identical throughout.
    task automatic memWait(input string tag, input logic [3:0] op,
                           input int waits, input ctrl_t exp);
        for (int i = 0; i < waits; i++) applyStimulus({tag, "_wait"}, op, 1'b0, exp);
        applyStimulus(tag, op, 1'b1, exp);
    endtask

    // One full instruction from FETCH back to FETCH (or into HALT). After
    // DECODE the Opcode input is scrambled to prove it was latched.
    task automatic runInstr(input logic [3:0] op, input int fetchWaits, input int memWaits);
        logic [3:0] junk;
        junk = op ^ 4'hA;
        for (int i = 0; i < fetchWaits; i++) applyStimulus("fetch_wait", junk, 1'b0, expFetch(1'b0));
        applyStimulus("fetch", junk, 1'b1, expFetch(1'b1));
        applyStimulus("decode", op, 1'b1, expDecode());
        case (op)
            4'h0, 4'h1, 4'hA, 4'hB: begin
                memWait("mrd", junk, memWaits, expMrd());
                applyStimulus("exec", junk, 1'b1, expExec(op));
            end
            4'h2: applyStimulus("exec_addi", junk, 1'b1, expExec(op));
            4'h3: begin
                memWait("mrd_load", junk, memWaits, expMrd());
                applyStimulus("lwb", junk, 1'b1, expLwb());
            end
            4'h4: memWait("st", junk, memWaits, expSt());
            4'h5, 4'h6: applyStimulus("br", junk, 1'b1, expBr(op == 4'h6));
            4'h7: applyStimulus("jmp", junk, 1'b1, expJmp());
            4'h8: begin
                applyStimulus("pdec", junk, 1'b1, expPdec());
                memWait("pwr", junk, memWaits, expPwr());
            end
            4'h9: begin
                memWait("prd", junk, memWaits, expPrd());
                applyStimulus("pinc", junk, 1'b1, expPinc());
            end
            default: begin
                for (int i = 0; i < 20; i++)
                    applyStimulus("halt", junk, 1'($urandom_range(0, 1)), expHalt());
            end
        endcase
    endtask

    initial begin
        reset    = 1'b1;
        Opcode   = 4'h0;
        MemReady = 1'b0;
        @(posedge CLK);
        #1;
        applyStimulus("reset_hold", 4'h0, 1'b0, expZero());
        reset = 1'b0;
        applyStimulus("rst_state", 4'h0, 1'b1, expZero());

        // Each instruction class, with assorted fetch and memory waits.
        runInstr(4'h0, 3, 0);
        runInstr(4'h1, 0, 1);
        runInstr(4'h2, 0, 0);
        runInstr(4'h3, 0, 2);
        runInstr(4'h4, 0, 1);
        runInstr(4'h5, 0, 0);
        runInstr(4'h6, 0, 0);
        runInstr(4'h7, 1, 0);
        runInstr(4'h8, 0, 0);
        runInstr(4'h9, 0, 3);
        runInstr(4'hA, 0, 0);
        runInstr(4'hB, 0, 1);

        // Reset in the middle of a PUSH memory wait.
        applyStimulus("fetch", 4'h0, 1'b1, expFetch(1'b1));
        applyStimulus("decode", 4'h8, 1'b1, expDecode());
        applyStimulus("pdec", 4'h8, 1'b0, expPdec());
        applyStimulus("pwr_wait", 4'h8, 1'b0, expPwr());
        reset = 1'b1;
        applyStimulus("pwr_reset", 4'h8, 1'b0, expPwr());
        reset = 1'b0;
        applyStimulus("rst_after_pwr", 4'h8, 1'b0, expZero());
        runInstr(4'h7, 1, 0);

        // Illegal opcode halts until reset.
        runInstr(4'hD, 0, 0);
        reset = 1'b1;
        applyStimulus("halt_reset", 4'h0, 1'b1, expHalt());
        reset = 1'b0;
        applyStimulus("rst_after_halt", 4'h0, 1'b1, expZero());
        runInstr(4'h2, 0, 0);

        // Explicit HALT opcode.
        runInstr(4'hF, 0, 0);
        reset = 1'b1;
        applyStimulus("halt_f_reset", 4'h0, 1'b0, expHalt());
        reset = 1'b0;
        applyStimulus("rst_after_halt_f", 4'h0, 1'b0, expZero());
        applyStimulus("fetch_after_halt_f", 4'h0, 1'b0, expFetch(1'b0));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
